// File: rtl/mux16_rr_arbiter_if.sv
// Bundle between the 16-way round-robin arbiter and the requesters it serves.
// The master side is the arbiter and the slave side is the requester pool.
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic [15:0] grant;
    logic        grant_valid;
    logic [3:0]  sel;
    logic        preempt;

    modport master (input req, output grant, output grant_valid, output sel, output preempt);
    modport slave  (output req, input grant, input grant_valid, input sel, input preempt);
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner arbiter for a shared 16:1 mux. It has an optional hold
// limit that revokes an owner which keeps requesting for MAX_HOLD cycles.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mux16_rr_arbiter_if.master    bus
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t           state_reg;
    logic [15:0]      grant_reg;
    logic             grant_valid_reg;
    logic [3:0]       sel_reg;
    logic             preempt_reg;
    logic [3:0]       ptr_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [3:0]  scan_base;
    logic [15:0] scan_vec;
    logic [15:0] rot;
    logic [3:0]  win_off;
    logic [3:0]  winner;
    logic        win_found;
    logic        owner_req;
    logic        hit_limit;

    // A handoff scans from owner+1, which is also the pointer value it leaves
    // behind, so one scanner serves both the idle and the handoff case.
    always_comb begin
        scan_base = ptr_reg;
        scan_vec  = bus.req;
        if (state_reg == OWN) begin
            scan_base = sel_reg + 4'd1;
            scan_vec  = bus.req & ~grant_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rot
            assign rot[gi] = scan_vec[scan_base + 4'(gi)];
        end
    endgenerate

    always_comb begin
        win_off = '0;
        for (int i = 15; i >= 0; i--) begin
            if (rot[i]) win_off = 4'(i);
        end
        win_found = |rot;
        winner    = scan_base + win_off;
    end

    assign owner_req = |(bus.req & grant_reg);
    assign hit_limit = (MAX_HOLD != 0) && (cnt_reg == HOLD_LAST) && owner_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            sel_reg         <= '0;
            preempt_reg     <= 1'b0;
            ptr_reg         <= '0;
            cnt_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    preempt_reg <= 1'b0;
                    if (win_found) begin
                        grant_reg       <= 16'd1 << winner;
                        sel_reg         <= winner;
                        grant_valid_reg <= 1'b1;
                        cnt_reg         <= '0;
                        state_reg       <= OWN;
                    end
                end
                OWN: begin
                    if (!owner_req || hit_limit) begin
                        ptr_reg     <= sel_reg + 4'd1;
                        preempt_reg <= hit_limit;
                        cnt_reg     <= '0;
                        if (win_found) begin
                            grant_reg <= 16'd1 << winner;
                            sel_reg   <= winner;
                        end else begin
                            // sel keeps the old owner so the mux select stays quiet.
                            grant_reg       <= '0;
                            grant_valid_reg <= 1'b0;
                            state_reg       <= IDLE;
                        end
                    end else begin
                        preempt_reg <= 1'b0;
                        if (MAX_HOLD != 0) cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.grant_valid = grant_valid_reg;
    assign bus.sel         = sel_reg;
    assign bus.preempt     = preempt_reg;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench: two arbiters (hold limit 8 and unlimited) share one request
// stream, and each is checked against a tenure-level reference model.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req_drv;

    mux16_rr_arbiter_if bus8 ();
    mux16_rr_arbiter_if bus0 ();

    assign bus8.req = req_drv;
    assign bus0.req = req_drv;

    mux16_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut8 (.clk(clk), .reset(rst), .bus(bus8));
    mux16_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut0 (.clk(clk), .reset(rst), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      r;
        logic [1:0][15:0] g;
        logic [1:0]       v;
        logic [1:0][3:0]  s;
        logic [1:0]       p;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Reference model state: owner (-1 = none), rotation start, cycles held so far.
    int mh    [2] = '{8, 0};
    int m_own [2];
    int m_ptr [2];
    int m_held[2];
    int m_sel [2];
    int m_pre [2];

    function automatic int pick(input logic [15:0] v, input int base);
        for (int i = 0; i < 16; i++) begin
            int k;
            k = (base + i) % 16;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic [15:0] r, input logic rs);
        int w;
        if (rs) begin
            m_own[d] = -1; m_ptr[d] = 0; m_held[d] = 0; m_sel[d] = 0; m_pre[d] = 0;
        end else if (m_own[d] < 0) begin
            m_pre[d] = 0;
            w = pick(r, m_ptr[d]);
            if (w >= 0) begin
                m_own[d] = w; m_sel[d] = w; m_held[d] = 1;
            end
        end else begin
            bit released, revoked;
            released = (r[m_own[d]] == 1'b0);
            revoked  = !released && mh[d] != 0 && m_held[d] == mh[d];
            if (released || revoked) begin
                logic [15:0] cand;
                cand = r;
                cand[m_own[d]] = 1'b0;
                m_ptr[d] = (m_own[d] + 1) % 16;
                m_pre[d] = revoked ? 1 : 0;
                w = pick(cand, m_ptr[d]);
                if (w >= 0) begin
                    m_own[d] = w; m_sel[d] = w; m_held[d] = 1;
                end else begin
                    m_own[d] = -1;
                end
            end else begin
                m_pre[d] = 0;
                m_held[d] = m_held[d] + 1;
            end
        end
    endtask

    task automatic cyc(input logic [15:0] r, input logic rs);
        exp_t e;
        @(negedge clk);
        req_drv = r;
        rst     = rs;
        e.r = r;
        for (int d = 0; d < 2; d++) begin
            model_step(d, r, rs);
            e.g[d] = (m_own[d] < 0) ? 16'h0 : (16'h1 << m_own[d]);
            e.v[d] = (m_own[d] >= 0);
            e.s[d] = 4'(m_sel[d]);
            e.p[d] = m_pre[d][0];
        end
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL txn=%0d %s dut_hold%0d got=%h want=%h", txn, name, mh[d], act, exp_v);
        end
    endtask

    // Monitor: outputs are registered, so each edge presents one response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                txn++;
                chk("grant", 0, bus8.grant, e.g[0]);
                chk("valid", 0, {15'h0, bus8.grant_valid}, {15'h0, e.v[0]});
                chk("sel",   0, {12'h0, bus8.sel}, {12'h0, e.s[0]});
                chk("preempt", 0, {15'h0, bus8.preempt}, {15'h0, e.p[0]});
                chk("grant", 1, bus0.grant, e.g[1]);
                chk("valid", 1, {15'h0, bus0.grant_valid}, {15'h0, e.v[1]});
                chk("sel",   1, {12'h0, bus0.sel}, {12'h0, e.s[1]});
                chk("preempt", 1, {15'h0, bus0.preempt}, {15'h0, e.p[1]});
                $display("txn %0d req=%h | h8 g=%h v=%0b s=%0d p=%0b | h0 g=%h v=%0b s=%0d p=%0b",
                         txn, e.r, bus8.grant, bus8.grant_valid, bus8.sel, bus8.preempt,
                         bus0.grant, bus0.grant_valid, bus0.sel, bus0.preempt);
            end
        end
    end

    initial begin
        logic [15:0] rr;
        rst     = 1'b1;
        req_drv = 16'h0;
        repeat (3) cyc(16'h0000, 1'b1);

        // Single request, then drop: sel must hold 4.
        repeat (3) cyc(16'h0010, 1'b0);
        repeat (2) cyc(16'h0000, 1'b0);

        // Two permanent requesters from ptr=0: alternating tenures.
        cyc(16'h8001, 1'b1);
        repeat (40) cyc(16'h8001, 1'b0);

        // Release handoff 3 -> 8 with no bubble.
        cyc(16'h0000, 1'b1);
        repeat (2) cyc(16'h0008, 1'b0);
        repeat (3) cyc(16'h0108, 1'b0);
        repeat (3) cyc(16'h0100, 1'b0);
        cyc(16'h0000, 1'b0);

        // Wrap-around: owner 14 releases to 0, then 5.
        cyc(16'h0000, 1'b1);
        repeat (2) cyc(16'h4000, 1'b0);
        repeat (2) cyc(16'h4021, 1'b0);
        repeat (3) cyc(16'h0021, 1'b0);
        repeat (3) cyc(16'h0020, 1'b0);
        cyc(16'h0000, 1'b0);

        // Long single tenure: unlimited arbiter never drops it.
        repeat (100) cyc(16'h0004, 1'b0);

        // Reset mid-tenure of owner 7, then ptr=0 gives 0 first.
        cyc(16'h0000, 1'b1);
        repeat (4) cyc(16'h0080, 1'b0);
        cyc(16'h0081, 1'b1);
        repeat (20) cyc(16'h0081, 1'b0);

        // Random request churn with occasional resets.
        rr = 16'h0;
        for (int n = 0; n < 1200; n++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 11) == 0) rr[b] = ~rr[b];
            end
            cyc(rr, ($urandom_range(0, 249) == 0));
        end
        repeat (16) cyc(16'hFFFF, 1'b0);
        repeat (140) cyc(16'hFFFF, 1'b0);

        @(posedge clk);
        #2;
        for (int i = 0; i < 5 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
